// File: rtl/report_collector_c5.sv
// Report collector for the cluster-5 stage-0 automata. It timestamps every
// cycle where run is high and any report bit fires, and queues that event in a small FIFO.
module report_collector_c5 #(
  parameter int NUM_REPORTS = 36,
  parameter int TS_WIDTH    = 16,
  parameter int DEPTH       = 8,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            run_i,
  input  logic [NUM_REPORTS-1:0]          report_vec_i,
  input  logic                            clear_flags_i,
  output logic                            rpt_valid_o,
  input  logic                            rpt_ready_i,
  output logic [TS_WIDTH+NUM_REPORTS-1:0] rpt_data_o,
  output logic [$clog2(DEPTH):0]          fifo_level_o,
  output logic                            overflow_o,
  output logic [DROP_WIDTH-1:0]           drop_count_o,
  output logic [TS_WIDTH-1:0]             ts_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_WIDTH + NUM_REPORTS;

  localparam logic [AW-1:0]         PTR_ONE  = 1;
  localparam logic [AW:0]           LVL_ONE  = 1;
  localparam logic [AW:0]           LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [TS_WIDTH-1:0]   TS_ONE   = 1;
  localparam logic [DROP_WIDTH-1:0] DROP_ONE = 1;

  logic [EW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;

  logic event_in, full, pop, push, drop;

  assign event_in = run_i && (report_vec_i != '0);
  assign full     = (level_q == LVL_FULL);
  assign pop      = (level_q != '0) && rpt_ready_i;
  // A pop in the same cycle frees the slot the new event needs, even when the FIFO is full.
  assign push     = event_in && (!full || pop);
  assign drop     = event_in && full && !pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    ts_d       = ts_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    if (run_i) ts_d = ts_q + TS_ONE;

    // A drop wins over clear_flags, so the drop in the clearing cycle counts as the first drop.
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_flags_i)  drop_d = DROP_ONE;
      else if (!(&drop_q)) drop_d = drop_q + DROP_ONE;
    end else if (clear_flags_i) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is cleared on reset so the head output reads zero after reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
        mem_q[gi] <= '0;
      else if (push && (wr_ptr_q == AW'(gi)))
        mem_q[gi] <= {ts_q, report_vec_i};
    end
  end

  assign rpt_valid_o  = (level_q != '0);
  assign rpt_data_o   = mem_q[rd_ptr_q];
  assign fifo_level_o = level_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_q;
  assign ts_o         = ts_q;

endmodule
